// File: rtl/case_demux_pkg.sv
// Shared types and constants for the registered 1-to-4 demultiplexer.
package case_demux_pkg;

   localparam int NUM_CH     = 4;
   localparam int DATA_W_DEF = 4;
   localparam int CNT_W_DEF  = 8;

   typedef logic [1:0]            sel_t;
   typedef logic [DATA_W_DEF-1:0] data_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel: a one-entry holding register with a valid/ready slot FSM
// and a saturating count of beats delivered to the consumer.
module demux_slot
   import case_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              accept,
   input  logic              drain,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  count
);

   slot_state_t       r_state;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_count;
   logic              w_drain;
   logic              w_cnt_max;

   assign w_drain   = drain && (r_state == FULL);
   assign w_cnt_max = (r_count == {CNT_W{1'b1}});

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         // NOTE: the holding register is reset because out_data must read 0
         // after reset; it is a single word, not a memory array.
         r_data  <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            EMPTY:   if (accept) r_state <= FULL;
            FULL:    if (w_drain && !accept) r_state <= EMPTY;
            default: r_state <= EMPTY;
         endcase

         if (accept) r_data <= data_in;

         if (w_drain && !w_cnt_max) r_count <= r_count + 1'b1;
      end
   end

   assign valid    = (r_state == FULL);
   assign data_out = r_data;
   assign count    = r_count;

endmodule

// File: rtl/case_demux.sv
// Registered 1-to-4 demultiplexer: steers each input beat to the channel named
// by sel; only the addressed channel can stall the producer.
module case_demux
   import case_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  sel_t              sel,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data0,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3,
   output logic              out_valid0,
   output logic              out_valid1,
   output logic              out_valid2,
   output logic              out_valid3,
   input  logic              out_ready0,
   input  logic              out_ready1,
   input  logic              out_ready2,
   input  logic              out_ready3,
   output logic [CNT_W-1:0]  count0,
   output logic [CNT_W-1:0]  count1,
   output logic [CNT_W-1:0]  count2,
   output logic [CNT_W-1:0]  count3
);

   logic [NUM_CH-1:0] w_accept;
   logic [NUM_CH-1:0] w_valid;
   logic [NUM_CH-1:0] w_ready;
   logic [NUM_CH-1:0] w_drain;
   logic [DATA_W-1:0] w_data  [NUM_CH];
   logic [CNT_W-1:0]  w_count [NUM_CH];
   logic              w_sel_valid;
   logic              w_sel_ready;

   assign w_ready = {out_ready3, out_ready2, out_ready1, out_ready0};
   assign w_drain = w_valid & w_ready;

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_accept    = '0;
      w_sel_valid = 1'b0;
      w_sel_ready = 1'b0;
      case (sel)
         2'b00: begin w_sel_valid = w_valid[0]; w_sel_ready = w_ready[0]; end
         2'b01: begin w_sel_valid = w_valid[1]; w_sel_ready = w_ready[1]; end
         2'b10: begin w_sel_valid = w_valid[2]; w_sel_ready = w_ready[2]; end
         2'b11: begin w_sel_valid = w_valid[3]; w_sel_ready = w_ready[3]; end
      endcase

      // Ready only looks at the addressed slot, so a stalled channel never
      // blocks beats headed elsewhere.
      in_ready = !w_sel_valid || w_sel_ready;

      if (in_valid && in_ready) begin
         case (sel)
            2'b00: w_accept[0] = 1'b1;
            2'b01: w_accept[1] = 1'b1;
            2'b10: w_accept[2] = 1'b1;
            2'b11: w_accept[3] = 1'b1;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
      demux_slot #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .accept   (w_accept[g]),
         .drain    (w_drain[g]),
         .data_in  (in_data),
         .valid    (w_valid[g]),
         .data_out (w_data[g]),
         .count    (w_count[g])
      );
   end

   assign out_valid0 = w_valid[0];
   assign out_valid1 = w_valid[1];
   assign out_valid2 = w_valid[2];
   assign out_valid3 = w_valid[3];
   assign out_data0  = w_data[0];
   assign out_data1  = w_data[1];
   assign out_data2  = w_data[2];
   assign out_data3  = w_data[3];
   assign count0     = w_count[0];
   assign count1     = w_count[1];
   assign count2     = w_count[2];
   assign count3     = w_count[3];

endmodule

// File: doc/case_demux.md
Name: case_demux

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the 4:1 select mux.
- Takes one 4-bit data stream tagged with a 2-bit select and steers each beat to one of four output channels.
- Each output channel has a one-entry holding register and a valid/ready handshake.
- Sits between a single producer and four independent consumers. Also serves as a positive test case for the synthesis flow: every select code is decoded, so no latches are inferred.

Parameters:
- DATA_W, 4, width of each data beat.
- CNT_W, 8, width of the per-channel beat counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  2  destination channel for the current input beat.
- in_data  input  DATA_W  input beat.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the beat addressed by sel this cycle.
- out_data0..out_data3  output  DATA_W  per-channel held data.
- out_valid0..out_valid3  output  1  per-channel holding register full.
- out_ready0..out_ready3  input  1  per-channel consumer accepts.
- count0..count3  output  CNT_W  saturating count of beats delivered on each channel.

Behaviour:
- Reset (rst_n low, asynchronous): all out_valid = 0, all out_data = 0, all count = 0. in_ready is combinational and therefore reads 1 during reset, but no transfer is accepted while rst_n is low.
- Input transfer: fires when in_valid and in_ready are both 1 at a rising edge.
- in_ready = !out_valid[sel] || out_ready[sel]. It depends only on the addressed channel, so a full channel does not block beats addressed to an empty channel.
- Latency: an accepted beat appears on out_data[sel] with out_valid[sel] = 1 on the next cycle (1-cycle latency).
- Output transfer on channel k: fires when out_valid[k] and out_ready[k] are both 1.
  - If no new beat for k is accepted in the same cycle, out_valid[k] goes to 0 next cycle.
  - count[k] increments by 1 and saturates at 2^CNT_W-1; it does not wrap.
- Simultaneous drain and fill on the same channel: out_valid[k] stays 1, out_data[k] takes the new beat, and count[k] increments for the drained beat. This gives full throughput of 1 beat/cycle per channel.
- Data stability: while out_valid[k] = 1 and out_ready[k] = 0, out_data[k] holds its value. in_data is never sampled into channel k unless a transfer addressed to k fires.
- Channel slot FSM (per channel), states EMPTY and FULL:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or on no drain.
  - out_valid[k] = (state == FULL).
- Non-addressed channels: ignore in_data completely.
- sel decode covers all four codes explicitly (00, 01, 10, 11), with default assignments ahead of the case. The design contains no latches.
- Reset mid-operation: all held beats are discarded, counters clear, and all channels return to EMPTY immediately.
- in_valid = 0: no state change except drains.

Decomposition:
- Package case_demux_pkg:
  - NUM_CH = 4.
  - typedef sel_t (logic[1:0]).
  - typedef data_t (logic[DATA_W-1:0]).
  - enum slot_state_t {EMPTY, FULL}.
- Sub-module demux_slot, instantiated 4 times:
  - Inputs: accept, drain, data_in.
  - Outputs: valid, data_out, count.
  - Contains the slot FSM, the holding register and the saturating counter.
- The top level contains only the sel decode and the in_ready mux.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with channel 2 FULL -> out_valid2 = 0, count2 = 0 immediately (before the next clk edge).
- Routing: send beats sel = 00/01/10/11 with data 4'h1/4'h2/4'h3/4'h4, all out_ready = 1 -> each out_datak equals its beat exactly one cycle after acceptance, and each countk = 1.
- Backpressure isolation: out_ready1 = 0, send sel = 01 data 4'hA, then sel = 01 data 4'hB -> second beat sees in_ready = 0 and out_data1 stays 4'hA. Then send sel = 11 data 4'hC -> in_ready = 1 and out_data3 = 4'hC next cycle.
- Throughput: out_ready0 = 1, stream 10 consecutive sel = 00 beats 0..9 -> in_ready stays 1 throughout, out_data0 shows 0..9 on consecutive cycles, and count0 = 10.
- Saturation: deliver 300 beats on channel 2 -> count2 stops at 8'hFF and does not wrap.
- Idle: in_valid = 0 with random sel and in_data -> no out_valid rises and no out_data changes.
